cmp_unit_pipe: RTL and testbench



---
 rtl/cmp_pkg.sv | 16 +
 rtl/cmp_core.sv | 24 ++
 rtl/cmp_unit_pipe.sv | 118 +++++++++++
 tb/tb_cmp_unit_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared constants for the pipelined ALU compare unit: function codes and widths.
package cmp_pkg;

  localparam int CMP_FUNC_W = 3;
  localparam int CMP_STAT_W = 16;

  localparam logic [CMP_FUNC_W-1:0] CMP_NOP = 3'd0;
  localparam logic [CMP_FUNC_W-1:0] CMP_EQ  = 3'd1;
  localparam logic [CMP_FUNC_W-1:0] CMP_GT  = 3'd2;
  localparam logic [CMP_FUNC_W-1:0] CMP_LT  = 3'd3;
  localparam logic [CMP_FUNC_W-1:0] CMP_NE  = 3'd4;
  localparam logic [CMP_FUNC_W-1:0] CMP_GE  = 3'd5;
  localparam logic [CMP_FUNC_W-1:0] CMP_MIN = 3'd6;
  localparam logic [CMP_FUNC_W-1:0] CMP_MAX = 3'd7;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude comparator producing eq/lt/gt for signed or unsigned operands.
module cmp_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  always_comb begin
    eq = (a == b);
    if (is_signed) begin
      lt = ($signed(a) < $signed(b));
      gt = ($signed(a) > $signed(b));
    end else begin
      lt = (a < b);
      gt = (a > b);
    end
  end

endmodule

// File: rtl/cmp_unit_pipe.sv
// Two-stage pipelined compare unit with valid/ready on both sides.
// Define CMP_STATS_EN to add a saturating counter of delivered true results.
module cmp_unit_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      A,
  input  logic [WIDTH-1:0]      B,
  input  logic [CMP_FUNC_W-1:0] CMP_ALU_FUNC,
  input  logic                  CMP_Signed,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  CMP_OUT,
  output logic                  CMP_True,
  output logic                  CMP_Flag,
  input  logic                  out_ready
`ifdef CMP_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [CMP_STAT_W-1:0] stat_true_cnt
`endif
);

  logic                  s1_valid;
  logic [WIDTH-1:0]      s1_a;
  logic [WIDTH-1:0]      s1_b;
  logic [CMP_FUNC_W-1:0] s1_func;
  logic                  s1_signed;

  logic                  s2_adv;
  logic                  s1_adv;
  logic                  eq;
  logic                  lt;
  logic                  gt;
  logic                  res_true;
  logic [WIDTH-1:0]      pick;
  logic [OUT_WIDTH-1:0]  res_out;

  // Ready chains combinationally from the output so a draining S2 frees S1 in the same cycle.
  assign s2_adv   = !CMP_Flag || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = !rst && s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= A;
        s1_b      <= B;
        s1_func   <= CMP_ALU_FUNC;
        s1_signed <= CMP_Signed;
      end
    end
  end

  cmp_core #(.WIDTH(WIDTH)) u_core (
    .a         (s1_a),
    .b         (s1_b),
    .is_signed (s1_signed),
    .eq        (eq),
    .lt        (lt),
    .gt        (gt)
  );

  // MIN/MAX prefer A on a tie, so selection of A is simply "not strictly worse".
  always_comb begin
    res_true = 1'b0;
    pick     = s1_a;
    res_out  = '0;
    case (s1_func)
      CMP_EQ:  res_true = eq;
      CMP_GT:  res_true = gt;
      CMP_LT:  res_true = lt;
      CMP_NE:  res_true = !eq;
      CMP_GE:  res_true = !lt;
      CMP_MIN: res_true = !gt;
      CMP_MAX: res_true = !lt;
      default: res_true = 1'b0;
    endcase
    if (s1_func == CMP_MIN || s1_func == CMP_MAX) begin
      pick    = res_true ? s1_a : s1_b;
      res_out = s1_signed ? OUT_WIDTH'($signed(pick)) : OUT_WIDTH'(pick);
    end else begin
      res_out = OUT_WIDTH'(res_true);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      CMP_Flag <= 1'b0;
      CMP_OUT  <= '0;
      CMP_True <= 1'b0;
    end else if (s2_adv) begin
      CMP_Flag <= s1_valid;
      if (s1_valid) begin
        CMP_OUT  <= res_out;
        CMP_True <= res_true;
      end
    end
  end

`ifdef CMP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_true_cnt <= '0;
    end else if (CMP_Flag && out_ready && CMP_True && (stat_true_cnt != '1)) begin
      stat_true_cnt <= stat_true_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cmp_unit_pipe.sv
// Self-checking bench for cmp_unit_pipe: spec-level result model, per-cycle compare, directed vectors.
module tb_cmp_unit_pipe;
  import cmp_pkg::*;

  typedef struct packed {
    logic [31:0] o;
    logic        t;
  } res_t;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic [15:0] a_in      = 16'd0;
  logic [15:0] b_in      = 16'd0;
  logic [2:0]  func      = 3'd0;
  logic        sgn       = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic [31:0] cmp_out;
  logic        cmp_true;
  logic        cmp_flag;
`ifdef CMP_STATS_EN
  logic        stat_clr  = 1'b0;
  logic [15:0] stat_cnt;
`endif

  int   n_vec   = 0;
  int   n_err   = 0;
  int   acc_cnt = 0;
  int   lb      = 0;
  int   base    = 0;
  res_t exp_q[$];
  res_t log_q[$];
  res_t exp_now;
  res_t prev_res;
  logic prev_hold = 1'b0;

  always #5 clk = ~clk;

  cmp_unit_pipe #(.WIDTH(16), .OUT_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .A            (a_in),
    .B            (b_in),
    .CMP_ALU_FUNC (func),
    .CMP_Signed   (sgn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .CMP_OUT      (cmp_out),
    .CMP_True     (cmp_true),
    .CMP_Flag     (cmp_flag),
    .out_ready    (out_ready)
`ifdef CMP_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_true_cnt(stat_cnt)
`endif
  );

  // Result defined directly from the operation's meaning on integer values.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] f, input logic s);
    longint av;
    longint bv;
    res_t   r;
    av = s ? longint'($signed(a)) : longint'({48'd0, a});
    bv = s ? longint'($signed(b)) : longint'({48'd0, b});
    r  = '0;
    case (f)
      CMP_EQ:  r.t = (av == bv);
      CMP_GT:  r.t = (av > bv);
      CMP_LT:  r.t = (av < bv);
      CMP_NE:  r.t = (av != bv);
      CMP_GE:  r.t = (av >= bv);
      CMP_MIN: r.t = (av <= bv);
      CMP_MAX: r.t = (av >= bv);
      default: r.t = 1'b0;
    endcase
    if (f == CMP_MIN || f == CMP_MAX) r.o = 32'(r.t ? av : bv);
    else                              r.o = {31'd0, r.t};
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic res_t getLog(input int i);
    if (i < log_q.size()) return log_q[i];
    return '1;
  endfunction

  // Present one operation and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] f, input logic s);
    bit ok;
    int n;
    a_in = a; b_in = b; func = f; sgn = s; in_valid = 1'b1;
    ok = 0; n = 0;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #2; n++;
    end while (!ok && n < 50);
    if (!ok) checkOutput("accept_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Per-cycle scoreboard: compare head of expected queue, check stall stability, record deliveries.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checkOutput("hold_flag", 32'(cmp_flag), 32'd1);
        checkOutput("hold_out",  cmp_out, prev_res.o);
        checkOutput("hold_true", 32'(cmp_true), 32'(prev_res.t));
      end
      if (cmp_flag) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 32'(cmp_flag), 32'd0);
        end else begin
          checkOutput("model_out",  cmp_out, exp_q[0].o);
          checkOutput("model_true", 32'(cmp_true), 32'(exp_q[0].t));
          if (out_ready) begin
            void'(exp_q.pop_front());
            log_q.push_back({cmp_out, cmp_true});
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_now = model(a_in, b_in, func, sgn);
        exp_q.push_back(exp_now);
        acc_cnt++;
      end
      prev_hold = cmp_flag && !out_ready;
      prev_res  = {cmp_out, cmp_true};
    end
  end

  initial begin
    idle(3);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_flag",     32'(cmp_flag), 32'd0);
    checkOutput("rst_out",      cmp_out, 32'd0);
    checkOutput("rst_true",     32'(cmp_true), 32'd0);
    checkOutput("post_rst_rdy", 32'(in_ready), 32'd1);

    // EQ 5==5 then GT 5>5 back-to-back, with exact latency.
    @(posedge clk); #2;
    a_in = 16'd5; b_in = 16'd5; func = CMP_EQ; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #2; func = CMP_GT;
    @(negedge clk);
    checkOutput("lat_flag_early", 32'(cmp_flag), 32'd0);
    @(posedge clk); #2; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("eq_flag", 32'(cmp_flag), 32'd1);
    checkOutput("eq_out",  cmp_out, 32'd1);
    checkOutput("eq_true", 32'(cmp_true), 32'd1);
    @(negedge clk);
    checkOutput("gt_flag", 32'(cmp_flag), 32'd1);
    checkOutput("gt_out",  cmp_out, 32'd0);
    checkOutput("gt_true", 32'(cmp_true), 32'd0);
    idle(3);

    // Signedness and MIN/MAX extension.
    lb = log_q.size();
    applyStimulus(16'hFFFF, 16'h0001, CMP_LT,  1'b1);
    applyStimulus(16'hFFFF, 16'h0001, CMP_LT,  1'b0);
    applyStimulus(16'h8000, 16'h0002, CMP_MIN, 1'b1);
    applyStimulus(16'h8000, 16'h0002, CMP_MAX, 1'b0);
    applyStimulus(16'd7,    16'd7,    CMP_MIN, 1'b0);
    applyStimulus(16'hFFFE, 16'hFFFE, CMP_NE,  1'b1);
    applyStimulus(16'hFFF0, 16'h0003, CMP_GE,  1'b1);
    applyStimulus(16'h1234, 16'hFFFF, CMP_MAX, 1'b1);
    applyStimulus(16'h1234, 16'h1234, CMP_NOP, 1'b1);
    idle(4);
    checkOutput("batch_count", 32'(log_q.size() - lb), 32'd9);
    checkOutput("lt_signed",   getLog(lb).o,       32'd1);
    checkOutput("lt_unsigned", getLog(lb + 1).o,   32'd0);
    checkOutput("min_s_out",   getLog(lb + 2).o,   32'hFFFF8000);
    checkOutput("min_s_true",  32'(getLog(lb + 2).t), 32'd1);
    checkOutput("max_u_out",   getLog(lb + 3).o,   32'h00008000);
    checkOutput("min_tie_out", getLog(lb + 4).o,   32'd7);
    checkOutput("min_tie_tru", 32'(getLog(lb + 4).t), 32'd1);
    checkOutput("ge_neg",      getLog(lb + 6).o,   32'd0);
    checkOutput("max_s_out",   getLog(lb + 7).o,   32'h00001234);
    checkOutput("nop_true",    32'(getLog(lb + 8).t), 32'd0);

    // Backpressure: four ops against a stalled output.
    out_ready = 1'b0;
    base = acc_cnt;
    lb   = log_q.size();
    fork
      begin
        applyStimulus(16'd1, 16'd1, CMP_EQ,  1'b0);
        applyStimulus(16'd1, 16'd2, CMP_NE,  1'b0);
        applyStimulus(16'd3, 16'd4, CMP_GE,  1'b0);
        applyStimulus(16'd0, 16'd0, CMP_NOP, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_accepts",  32'(acc_cnt - base), 32'd2);
        @(posedge clk); #2; out_ready = 1'b1;
      end
    join
    idle(5);
    checkOutput("bp_count", 32'(log_q.size() - lb), 32'd4);
    checkOutput("bp_r0", getLog(lb).o,     32'd1);
    checkOutput("bp_r1", getLog(lb + 1).o, 32'd1);
    checkOutput("bp_r2", getLog(lb + 2).o, 32'd0);
    checkOutput("bp_r3", getLog(lb + 3).o, 32'd0);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    applyStimulus(16'd9, 16'd9, CMP_EQ, 1'b0);
    applyStimulus(16'd1, 16'd2, CMP_LT, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #2; rst = 1'b0;
    lb = log_q.size();
    @(negedge clk);
    checkOutput("mid_rst_flag",  32'(cmp_flag), 32'd0);
    checkOutput("mid_rst_out",   cmp_out, 32'd0);
    checkOutput("mid_rst_ready2", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    idle(6);
    checkOutput("mid_rst_stale", 32'(log_q.size() - lb), 32'd0);

`ifdef CMP_STATS_EN
    @(posedge clk); #2; stat_clr = 1'b1;
    @(posedge clk); #2; stat_clr = 1'b0;
    applyStimulus(16'd1, 16'd1, CMP_EQ, 1'b0);
    applyStimulus(16'd1, 16'd2, CMP_EQ, 1'b0);
    applyStimulus(16'd2, 16'd1, CMP_GT, 1'b0);
    applyStimulus(16'd2, 16'd1, CMP_LT, 1'b0);
    applyStimulus(16'd4, 16'd4, CMP_GE, 1'b0);
    idle(4);
    checkOutput("stat_three", 32'(stat_cnt), 32'd3);
    applyStimulus(16'd1, 16'd1, CMP_EQ, 1'b0);
    @(posedge clk); #2; stat_clr = 1'b1;
    @(posedge clk); #2; stat_clr = 1'b0;
    @(negedge clk);
    checkOutput("stat_clr_wins", 32'(stat_cnt), 32'd0);
    for (int i = 0; i < 65540; i++) applyStimulus(16'd3, 16'd3, CMP_EQ, 1'b0);
    idle(4);
    checkOutput("stat_saturate", 32'(stat_cnt), 32'h0000FFFF);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
